alu32_dispatch: RTL and testbench
=================================

Name: alu32_dispatch

Overview:
Initiator-side front end for the 32-bit tagged ALU interface. It accepts operation requests over a valid/ready handshake and tags each one with a fresh nonzero key. It drives the ALU's en/clr/op/key/operand ports for the exact number of enable cycles the op needs, then matches the returned key and presents the result over a second valid/ready handshake. It sits between the command decoder and the ALU; one operation is outstanding at a time.

Parameters:
MUL_CYCLES, 4, number of consecutive alu_en cycles issued for op MUL.
TIMEOUT, 16, number of WAIT cycles without a key match before the op is aborted.
KEY_W, 8, key width.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
clr  in  1  synchronous abort: drop the current op, pulse alu_clr, return to IDLE
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready at the clock edge
req_op  in  2  00 NOP, 01 ADD, 10 SUB, 11 MUL
req_a  in  32  operand A
req_b  in  32  operand B
res_valid  out  1  result present
res_ready  in  1  result consumed when res_valid && res_ready at the clock edge
res_data  out  32  result value
res_key  out  KEY_W  key of the op
res_err  out  1  op aborted by timeout
alu_en  out  1  ALU enable
alu_clr  out  1  ALU synchronous clear
alu_op  out  2  ALU op
alu_key  out  KEY_W  ALU key_in
alu_a  out  32  ALU inA
alu_b  out  32  ALU inB
alu_out  in  32  ALU result
alu_key_out  in  KEY_W  ALU returned key; 0 means no result

Behaviour:
- Reset (async): state IDLE; all outputs 0, except next_key=1. req_ready is 1 after reset.
- States: IDLE, ISSUE, WAIT, DONE, ABORT.
- IDLE:
  - req_ready=1.
  - On accept, register req_op/a/b into alu_op/alu_a/alu_b, set alu_key=next_key, and advance next_key (255 wraps to 1; 0 is never issued).
  - Load the enable counter with MUL_CYCLES for MUL and 1 otherwise, then go to ISSUE.
- ISSUE:
  - alu_en=1; the counter decrements each cycle.
  - When the counter reaches 1, go to WAIT.
  - alu_en must never exceed the counter length: an extra MUL enable corrupts the ALU's internal phase.
- WAIT:
  - alu_en=0; alu_op/key/a/b stay stable.
  - If alu_key_out==alu_key: capture alu_out into res_data and alu_key into res_key, set res_err=0, go to DONE.
  - Otherwise increment the timeout counter. At TIMEOUT go to ABORT.
- ABORT: alu_clr=1 for exactly one cycle; set res_data=0, res_key=alu_key, res_err=1; go to DONE.
- DONE: res_valid=1 with data held stable. On res_ready go to IDLE; res_valid drops on that same edge.
- Latency, accept edge to res_valid high:
  - ADD/SUB/NOP: 2 cycles.
  - MUL: MUL_CYCLES+1 cycles.
  - Timeout: TIMEOUT+2 cycles.
- Only IDLE asserts req_ready, so back-to-back throughput is latency+1 cycles when res_ready is held high.
- SUB and NOP are forwarded unchanged. The ALU returns 0 with the key echoed, and the result is 0 with res_err=0.
- Stale keys: the previous key differs from the newly issued key, and the ALU holds its outputs while alu_en=0. No match is possible before the new op completes.
- clr in any state:
  - Next cycle is IDLE with alu_en=0 and res_valid=0; alu_clr=1 for one cycle.
  - next_key is preserved.
  - clr takes priority over accept and over a key match on the same edge.
- rst mid-operation: immediate return to reset values; any pending result is lost.

Decomposition:
- Shared package holds:
  - op encodings OP_NOP=00, OP_ADD=01, OP_SUB=10, OP_MUL=11
  - KEY_W
  - KEY_NONE=0
  - the state enum
- Natural sub-module: alu_key_gen, a nonzero wrapping key counter with an advance strobe. It resets to 1, goes 255 to 1, and never produces 0.

Test Plan:
- ADD 5+7 with an alu32 model: res_valid 2 cycles after accept, res_data=12, res_key=1, res_err=0, alu_en high exactly 1 cycle.
- MUL 0x0003*0x0004: alu_en high exactly 4 cycles, res_data=12 at accept+5, res_key=2; a following ADD also returns the correct result, proving the ALU phase is intact.
- Backpressure: hold res_ready=0 for 10 cycles after ADD 1+1. res_valid and res_data=2 stay stable and req_ready=0 throughout; they are released one edge after res_ready=1.
- Timeout: stub the ALU to keep alu_key_out=0. At accept+TIMEOUT+1 alu_clr pulses once; res_valid then follows with res_err=1 and res_data=0.
- Key wrap: issue 256 NOPs. Keys run 1..255 then 1; key 0 is never driven on alu_key.
- Abort: assert clr during the 3rd MUL enable cycle. alu_en drops, alu_clr pulses once, and no result is produced. Then assert rst asynchronously mid-ADD: all outputs return to 0 immediately and the next accepted op carries key 1.

Source files
------------

// File: rtl/alu32_dispatch_pkg.sv
// Shared definitions for the tagged 32-bit ALU dispatch front end.
package alu32_dispatch_pkg;

    // Key width and the reserved "no result" key value.
    localparam int KEY_W = 8;
    localparam logic [KEY_W-1:0] KEY_NONE = '0;

    // ALU operation encodings.
    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_MUL = 2'b11
    } op_e;

    // Dispatch FSM states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_e;

endpackage

// File: rtl/alu32_dispatch_key_gen.sv
// Nonzero wrapping key counter: resets to 1, advances on strobe, all-ones wraps to 1.
module alu_key_gen #(
    parameter int KEY_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    output logic [KEY_W-1:0] key
);

    // Advance the key, skipping 0 so a key can never look like "no result".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key <= KEY_W'(1);
        end else if (adv) begin
            key <= (key == {KEY_W{1'b1}}) ? KEY_W'(1) : key + KEY_W'(1);
        end
    end

endmodule

// File: rtl/alu32_dispatch.sv
// Initiator-side front end for the tagged ALU: tags requests with a fresh key,
// drives the exact enable count per op, matches the returned key and presents
// the result. One operation outstanding at a time.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high; valid, once raised, holds its payload stable until that edge.
module alu32_dispatch
    import alu32_dispatch_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [KEY_W-1:0] res_key,
    output logic             res_err,
    output logic             alu_en,
    output logic             alu_clr,
    output logic [1:0]       alu_op,
    output logic [KEY_W-1:0] alu_key,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_out,
    input  logic [KEY_W-1:0] alu_key_out,
    output state_e           dbg_state
);

    localparam int EW = $clog2(MUL_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e           state, state_d;
    logic             accept;
    logic             key_match;
    logic [EW-1:0]    en_cnt;
    logic [TW-1:0]    t_cnt;
    logic [KEY_W-1:0] next_key;

    // Only advance the key on a real accept (clr suppresses accept).
    alu_key_gen #(.KEY_W(KEY_W)) u_key_gen (
        .clk (clk),
        .rst (rst),
        .adv (accept),
        .key (next_key)
    );

    assign req_ready = (state == S_IDLE);
    assign res_valid = (state == S_DONE);
    assign alu_en    = (state == S_ISSUE);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next-state logic; clr overrides accept and key match.
    always_comb begin
        state_d   = state;
        accept    = 1'b0;
        key_match = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (en_cnt == EW'(1)) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (alu_key_out == alu_key) begin
                    key_match = 1'b1;
                    state_d   = S_DONE;
                end else if (t_cnt == TW'(TIMEOUT - 1)) begin
                    state_d = S_ABORT;
                end
            end
            S_ABORT: state_d = S_DONE;
            S_DONE: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (clr) begin
            state_d   = S_IDLE;
            accept    = 1'b0;
            key_match = 1'b0;
        end
    end

    // Datapath: ALU command registers, enable/timeout counters, result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_clr  <= 1'b0;
            alu_op   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_key  <= KEY_NONE;
            en_cnt   <= '0;
            t_cnt    <= '0;
            res_data <= '0;
            res_key  <= KEY_NONE;
            res_err  <= 1'b0;
        end else begin
            // One-cycle ALU clear on abort entry or external clr.
            alu_clr <= clr || (state_d == S_ABORT);

            if (accept) begin
                alu_op  <= req_op;
                alu_a   <= req_a;
                alu_b   <= req_b;
                alu_key <= next_key;
                en_cnt  <= (req_op == OP_MUL) ? EW'(MUL_CYCLES) : EW'(1);
            end else if (state == S_ISSUE) begin
                en_cnt <= en_cnt - EW'(1);
            end

            // Counts consecutive WAIT cycles without a match.
            if (state == S_WAIT) t_cnt <= t_cnt + TW'(1);
            else                 t_cnt <= '0;

            if (key_match) begin
                res_data <= alu_out;
                res_key  <= alu_key;
                res_err  <= 1'b0;
            end else if (state == S_ABORT) begin
                res_data <= '0;
                res_key  <= alu_key;
                res_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu32_dispatch.sv
// Self-checking bench for alu32_dispatch with a behavioural tagged-ALU model.
module tb_alu32_dispatch;
    import alu32_dispatch_pkg::*;

    localparam int MUL_CYCLES = 4;
    localparam int TIMEOUT    = 16;
    // Expected entry: {clr_cnt[3:0], en_cnt[3:0], lat[7:0], data[31:0], key[7:0], err}
    localparam int EXP_W = 57;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = 2'b00;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [31:0]      res_data;
    logic [KEY_W-1:0] res_key;
    logic             res_err;
    logic             alu_en;
    logic             alu_clr;
    logic [1:0]       alu_op;
    logic [KEY_W-1:0] alu_key;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [31:0]      alu_out;
    logic [KEY_W-1:0] alu_key_out;
    state_e           dbg_state;

    // ALU model state
    logic [31:0]      m_out;
    logic [KEY_W-1:0] m_key;
    logic [3:0]       m_phase;
    logic             stub_dead = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int tb_en_cnt  = 0;
    int tb_clr_cnt = 0;
    logic [KEY_W-1:0] tb_key = 8'd1;
    logic [EXP_W-1:0] exp_q[$];
    int acc_q[$];

    alu32_dispatch #(.MUL_CYCLES(MUL_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_key(res_key), .res_err(res_err),
        .alu_en(alu_en), .alu_clr(alu_clr), .alu_op(alu_op), .alu_key(alu_key),
        .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_key_out(alu_key_out),
        .dbg_state(dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Tagged ALU model: ADD sums, MUL needs MUL_CYCLES enables, SUB/NOP return 0.
    always @(posedge clk or posedge rst) begin
        if (rst || alu_clr) begin
            m_out <= '0; m_key <= '0; m_phase <= '0;
        end else if (alu_en) begin
            case (alu_op)
                2'b01: begin m_out <= alu_a + alu_b; m_key <= alu_key; end
                2'b11: begin
                    if (m_phase == 4'(MUL_CYCLES - 1)) begin
                        m_out <= alu_a * alu_b; m_key <= alu_key; m_phase <= '0;
                    end else begin
                        m_phase <= m_phase + 4'd1;
                    end
                end
                default: begin m_out <= '0; m_key <= alu_key; end
            endcase
        end
    end
    assign alu_out     = m_out;
    assign alu_key_out = stub_dead ? '0 : m_key;

    // Per-op enable and clear pulse counters, restarted on each accept
    always @(posedge clk) begin
        if (req_valid && req_ready) begin
            tb_en_cnt <= 0; tb_clr_cnt <= 0;
        end else begin
            if (alu_en)  tb_en_cnt  <= tb_en_cnt + 1;
            if (alu_clr) tb_clr_cnt <= tb_clr_cnt + 1;
        end
    end

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard monitor: compares each delivered result against the queue head
    int  seen_cyc = 0;
    bit  seen = 0;
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        int a0;
        int lat;
        if (rst) begin
            seen = 0;
        end else begin
            if (alu_en) check(alu_key != 8'd0, "key_nonzero", alu_key, 1);
            if (res_valid && !seen) begin seen = 1; seen_cyc = cyc; end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check(0, "unexpected_result", res_data, 0);
                end else begin
                    e = exp_q.pop_front();
                    a0 = acc_q.pop_front();
                    lat = seen_cyc - a0 - 1;
                    check(res_data == e[40:9], "res_data", res_data, e[40:9]);
                    check(res_key  == e[8:1],  "res_key",  res_key,  e[8:1]);
                    check(res_err  == e[0],    "res_err",  res_err,  e[0]);
                    check(lat == int'(e[48:41]), "latency", lat, e[48:41]);
                    check(tb_en_cnt == int'(e[52:49]), "en_cycles", tb_en_cnt, e[52:49]);
                    check(tb_clr_cnt == int'(e[56:53]), "clr_pulses", tb_clr_cnt, e[56:53]);
                end
                seen = 0;
            end
        end
    end

    // Driver: present one request; optionally push its expected result
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_data, input bit exp_err, input int lat,
                         input int en_exp, input bit push);
        int n = 0;
        @(posedge clk); #1;
        while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
        check(req_ready, "req_ready_wait", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        if (push) begin
            exp_q.push_back({4'(exp_err ? 1 : 0), 4'(en_exp), 8'(lat), exp_data, tb_key, exp_err});
            acc_q.push_back(cyc);
        end
        tb_key = (tb_key == 8'hFF) ? 8'd1 : tb_key + 8'd1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 500) begin @(posedge clk); #1; n++; end
        check(n < 500, "wait_done_timeout", n, 500);
    endtask

    initial begin
        // Reset values
        #2;
        check(req_ready == 1'b1, "rst_req_ready", req_ready, 1);
        check(res_valid == 1'b0, "rst_res_valid", res_valid, 0);
        check(alu_en == 1'b0,    "rst_alu_en", alu_en, 0);
        check(alu_clr == 1'b0,   "rst_alu_clr", alu_clr, 0);
        check(alu_key == 8'd0,   "rst_alu_key", alu_key, 0);
        check(res_key == 8'd0,   "rst_res_key", res_key, 0);
        check(dbg_state == S_IDLE, "rst_state", dbg_state, S_IDLE);
        #20 rst = 1'b0;

        // Directed ops: ADD, MUL, ADD after MUL, SUB
        issue(2'b01, 32'd5, 32'd7, 32'd12, 0, 2, 1, 1);
        wait_done();
        issue(2'b11, 32'h3, 32'h4, 32'd12, 0, MUL_CYCLES + 1, MUL_CYCLES, 1);
        wait_done();
        issue(2'b01, 32'hFFFF_FFFF, 32'd2, 32'd1, 0, 2, 1, 1);
        wait_done();

        // Backpressure: hold result 10 cycles
        res_ready = 1'b0;
        issue(2'b01, 32'd1, 32'd1, 32'd2, 0, 2, 1, 1);
        begin
            int n = 0;
            while (!res_valid && n < 50) begin @(posedge clk); #1; n++; end
            check(res_valid, "bp_valid_wait", res_valid, 1);
        end
        repeat (10) begin
            @(posedge clk); #1;
            check(res_valid && res_data == 32'd2 && !req_ready, "bp_hold",
                  {res_valid, req_ready, res_data}, {2'b10, 32'd2});
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        check(!res_valid, "bp_release", res_valid, 0);
        check(req_ready, "bp_release_ready", req_ready, 1);

        // Timeout: ALU never echoes the key
        stub_dead = 1'b1;
        issue(2'b01, 32'd3, 32'd4, 32'd0, 1, TIMEOUT + 2, 1, 1);
        wait_done();
        stub_dead = 1'b0;

        // SUB is forwarded; the ALU returns 0
        issue(2'b10, 32'd9, 32'd3, 32'd0, 0, 2, 1, 1);
        wait_done();

        // Key wrap across 256 NOPs
        for (int i = 0; i < 256; i++) issue(2'b00, i, 32'd0, 32'd0, 0, 2, 1, 1);
        wait_done();

        // clr during 3rd MUL enable cycle
        issue(2'b11, 32'd6, 32'd7, 32'd0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check(alu_en, "abort_third_en", alu_en, 1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check(!alu_en, "abort_en_drop", alu_en, 0);
        check(alu_clr, "abort_clr_pulse", alu_clr, 1);
        check(req_ready && !res_valid, "abort_idle", {req_ready, res_valid}, 2'b10);
        check(tb_en_cnt == 3, "abort_en_count", tb_en_cnt, 3);
        @(posedge clk); #1;
        check(!alu_clr, "abort_clr_once", alu_clr, 0);
        begin
            bit any_valid = 0;
            repeat (20) begin @(posedge clk); #1; if (res_valid) any_valid = 1; end
            check(!any_valid, "abort_no_result", any_valid, 0);
        end

        // Asynchronous reset mid-ADD
        issue(2'b01, 32'd2, 32'd3, 32'd0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check(!alu_en && !alu_clr && !res_valid && req_ready, "rst_mid_ctrl",
              {alu_en, alu_clr, res_valid, req_ready}, 4'b0001);
        check(alu_key == 8'd0 && alu_op == 2'd0, "rst_mid_key_op", {alu_key, alu_op}, 0);
        check(alu_a == 32'd0 && alu_b == 32'd0, "rst_mid_operands", {alu_a, alu_b}, 0);
        #3 rst = 1'b0;
        tb_key = 8'd1;
        issue(2'b01, 32'd9, 32'd10, 32'd19, 0, 2, 1, 1);
        wait_done();

        repeat (3) @(posedge clk);
        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
